// File: rtl/game_io_regbank_pkg.sv
// Shared constants for the game I/O register bank: register map, sound channel ids, hold defaults.
package game_io_regbank_pkg;

   localparam int REG_GAME_STATE = 0;
   localparam int REG_BIRD_Y     = 1;
   localparam int REG_SCORE      = 2;

   localparam int SFX_JUMP  = 0;
   localparam int SFX_SCORE = 1;
   localparam int SFX_DEATH = 2;

   localparam int DEFAULT_TRIG_HOLD = 64;

   typedef enum logic [1:0] {
      SFX_CH_JUMP  = 2'd0,
      SFX_CH_SCORE = 2'd1,
      SFX_CH_DEATH = 2'd2
   } sfx_ch_e;

   // The sound trigger port sits directly above the last general register.
   function automatic int sfx_addr(input int num_regs);
      return num_regs;
   endfunction

   function automatic int hold_cnt_w(input int hold);
      return $clog2(hold + 1);
   endfunction

endpackage

// File: rtl/game_io_regbank_sfx_pulse_stretcher.sv
// One sound-effect channel: a load starts (or restarts) a pulse that stays high for HOLD cycles.
module sfx_pulse_stretcher
   import game_io_regbank_pkg::*;
#(
   parameter int HOLD = DEFAULT_TRIG_HOLD
) (
   input  logic iClock,
   input  logic iReset,
   input  logic iLoad,
   output logic oPulse
);

   localparam int CNT_W = hold_cnt_w(HOLD);

   logic [CNT_W-1:0] cnt;

   // oPulse mirrors (cnt != 0) but comes from its own flop so the output is glitch-free.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         cnt    <= '0;
         oPulse <= 1'b0;
      end else if (iLoad) begin
         cnt    <= CNT_W'(HOLD);
         oPulse <= 1'b1;
      end else begin
         if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         oPulse <= (cnt > CNT_W'(1));
      end
   end

endmodule

// File: rtl/game_io_regbank.sv
// Addressed processor write port feeding game registers and stretched sound triggers.
// Optional macro GAME_IO_SHADOW_COMMIT_EN: oRegs becomes a shadow committed on iFrameSync.
module game_io_regbank
   import game_io_regbank_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 4,
   parameter int ADDR_W    = 3,
   parameter int NUM_SFX   = 3,
   parameter int TRIG_HOLD = DEFAULT_TRIG_HOLD
) (
   input  logic                         iClock,
   input  logic                         iReset,
   input  logic                         iWrEn,
   input  logic [ADDR_W-1:0]            iWrAddr,
   input  logic [DATA_W-1:0]            iWrData,
   input  logic [ADDR_W-1:0]            iRdAddr,
   output logic [DATA_W-1:0]            oRdData,
   input  logic                         iFrameSync,
   output logic [NUM_REGS*DATA_W-1:0]   oRegs,
   output logic [NUM_SFX-1:0]           oSfxTrig,
   output logic                         oWrErr
);

   localparam logic [ADDR_W-1:0] SFX_ADDR = ADDR_W'(sfx_addr(NUM_REGS));

   logic [DATA_W-1:0] live [NUM_REGS];
   logic [NUM_SFX-1:0] sfx_load;
   logic               sfx_wr;
   logic               sfx_bad;
   logic               unmapped_wr;
   logic [DATA_W-1:0]  rd_next;

   assign sfx_wr      = iWrEn && (iWrAddr == SFX_ADDR);
   assign sfx_bad     = sfx_wr && (iWrData >= DATA_W'(NUM_SFX));
   assign unmapped_wr = iWrEn && (iWrAddr > SFX_ADDR);

   for (genvar c = 0; c < NUM_SFX; c++) begin : g_sfx
      assign sfx_load[c] = sfx_wr && (iWrData == DATA_W'(c));

      sfx_pulse_stretcher #(
         .HOLD(TRIG_HOLD)
      ) u_stretch (
         .iClock (iClock),
         .iReset (iReset),
         .iLoad  (sfx_load[c]),
         .oPulse (oSfxTrig[c])
      );
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            live[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (iWrEn && (iWrAddr == ADDR_W'(k))) begin
               live[k] <= iWrData;
            end
         end
      end
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         oWrErr <= 1'b0;
      end else if (sfx_bad || unmapped_wr) begin
         oWrErr <= 1'b1;
      end
   end

   // Readback samples pre-edge state, so a same-cycle write returns the old value.
   always_comb begin
      rd_next = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (iRdAddr == ADDR_W'(k)) begin
            rd_next = live[k];
         end
      end
      if (iRdAddr == SFX_ADDR) begin
         rd_next = DATA_W'(oSfxTrig);
      end
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         oRdData <= '0;
      end else begin
         oRdData <= rd_next;
      end
   end

`ifdef GAME_IO_SHADOW_COMMIT_EN
   logic [DATA_W-1:0] shadow [NUM_REGS];

   // Commit takes the incoming write directly so a write on the sync cycle lands this frame.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            shadow[k] <= '0;
         end
      end else if (iFrameSync) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (iWrEn && (iWrAddr == ADDR_W'(k))) begin
               shadow[k] <= iWrData;
            end else begin
               shadow[k] <= live[k];
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign oRegs[k*DATA_W +: DATA_W] = shadow[k];
   end
`else
   wire unused_frame_sync = iFrameSync;

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign oRegs[k*DATA_W +: DATA_W] = live[k];
   end
`endif

endmodule

// File: tb/tb_game_io_regbank.sv
// Randomised and directed bench for game_io_regbank against a cycle-indexed behavioural model.
module tb_game_io_regbank;

  localparam int DW   = 32;
  localparam int NR   = 3;
  localparam int AW   = 3;
  localparam int NS   = 3;
  localparam int HOLD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [AW-1:0]     rd_addr;
  logic              frame_sync;
  logic [DW-1:0]     rd_data;
  logic [NR*DW-1:0]  regs_flat;
  logic [NS-1:0]     sfx_trig;
  logic              wr_err;

  int n_tests = 0;
  int n_fail  = 0;

  // model: register contents, shadow copy, edge index of the last trigger per channel
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_shadow [NR];
  int            last_load [NS];
  int            edge_n;
  logic          m_err;
  logic [DW-1:0] m_rd;

  game_io_regbank #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_SFX(NS), .TRIG_HOLD(HOLD)
  ) dut (
    .iClock(clk), .iReset(rst), .iWrEn(wr_en), .iWrAddr(wr_addr), .iWrData(wr_data),
    .iRdAddr(rd_addr), .oRdData(rd_data), .iFrameSync(frame_sync), .oRegs(regs_flat),
    .oSfxTrig(sfx_trig), .oWrErr(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // a channel is high for the HOLD edges starting at the edge that loaded it
  function automatic logic [NS-1:0] exp_trig();
    logic [NS-1:0] r;
    for (int c = 0; c < NS; c++) r[c] = (edge_n - last_load[c]) < HOLD;
    return r;
  endfunction

  function automatic logic [NR*DW-1:0] exp_regs();
    logic [NR*DW-1:0] r;
    for (int k = 0; k < NR; k++) begin
`ifdef GAME_IO_SHADOW_COMMIT_EN
      r[k*DW +: DW] = m_shadow[k];
`else
      r[k*DW +: DW] = m_regs[k];
`endif
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      m_regs[k]   = '0;
      m_shadow[k] = '0;
    end
    for (int c = 0; c < NS; c++) last_load[c] = -1000;
    m_err = 1'b0;
    m_rd  = '0;
  endtask

  task automatic model_edge();
    if (int'(rd_addr) < NR) m_rd = m_regs[int'(rd_addr)];
    else if (int'(rd_addr) == NR) m_rd = DW'(exp_trig());
    else m_rd = '0;
    edge_n++;
    if (wr_en) begin
      if (int'(wr_addr) < NR) m_regs[int'(wr_addr)] = wr_data;
      else if (int'(wr_addr) == NR) begin
        if (wr_data < NS) last_load[int'(wr_data)] = edge_n;
        else m_err = 1'b1;
      end else m_err = 1'b1;
    end
    if (frame_sync) for (int k = 0; k < NR; k++) m_shadow[k] = m_regs[k];
  endtask

  task automatic check_all();
    check_eq("rd_data", rd_data, m_rd);
    check_eq("sfx_trig", sfx_trig, exp_trig());
    check_eq("wr_err", wr_err, m_err);
    check_eq("regs", regs_flat, exp_regs());
  endtask

  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input logic fs);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra; frame_sync = fs;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // reset asserted mid-cycle: outputs must clear before any clock edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    wr_en = 1'b0; frame_sync = 1'b0;
    rst = 1'b1;
    #1;
    check_eq({tag, "_trig"}, sfx_trig, 0);
    check_eq({tag, "_regs"}, regs_flat, 0);
    check_eq({tag, "_rd"}, rd_data, 0);
    check_eq({tag, "_err"}, wr_err, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; frame_sync = 1'b0;
    edge_n = 0;
    model_reset();
    #3;
    check_eq("reset_rd", rd_data, 0);
    check_eq("reset_trig", sfx_trig, 0);
    check_eq("reset_regs", regs_flat, 0);
    check_eq("reset_err", wr_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // write then readback of reg 1
    cycle(1'b1, 3'd1, 32'h0000_00F0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 32'h0, 3'd1, 1'b0);
    check_eq("rd_f0", rd_data, 32'hF0);
`ifndef GAME_IO_SHADOW_COMMIT_EN
    check_eq("regs1_f0", regs_flat[63:32], 32'hF0);
`endif

    // single trigger on channel 1 lasts HOLD cycles
    hi_cnt = 0;
    cycle(1'b1, 3'd3, 32'd1, 3'd0, 1'b0);
    check_eq("trig_first", sfx_trig, 3'b010);
    if (sfx_trig == 3'b010) hi_cnt++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, 32'd0, 3'd3, 1'b0);
      if (sfx_trig == 3'b010) hi_cnt++;
    end
    check_eq("trig_len", hi_cnt, 4);

    // retrigger two cycles in extends to 6
    hi_cnt = 0;
    cycle(1'b1, 3'd3, 32'd1, 3'd0, 1'b0);
    if (sfx_trig == 3'b010) hi_cnt++;
    cycle(1'b0, 3'd0, 32'd0, 3'd0, 1'b0);
    if (sfx_trig == 3'b010) hi_cnt++;
    cycle(1'b1, 3'd3, 32'd1, 3'd0, 1'b0);
    if (sfx_trig == 3'b010) hi_cnt++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, 32'd0, 3'd0, 1'b0);
      if (sfx_trig == 3'b010) hi_cnt++;
    end
    check_eq("retrig_len", hi_cnt, 6);

    // bad channel and unmapped address set the sticky error
    cycle(1'b1, 3'd3, 32'd7, 3'd0, 1'b0);
    check_eq("err_badch", wr_err, 1);
    check_eq("trig_badch", sfx_trig, 0);
    cycle(1'b1, 3'd6, 32'hDEAD, 3'd6, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 32'd0, 3'd0, 1'b0);
    check_eq("err_sticky", wr_err, 1);

    // same-cycle read/write returns the old value
    cycle(1'b1, 3'd2, 32'd7, 3'd0, 1'b0);
    cycle(1'b1, 3'd2, 32'd9, 3'd2, 1'b0);
    check_eq("rw_old", rd_data, 7);
    cycle(1'b0, 3'd0, 32'd0, 3'd2, 1'b0);
    check_eq("rw_new", rd_data, 9);

`ifdef GAME_IO_SHADOW_COMMIT_EN
    do_reset("rst_a");
    cycle(1'b1, 3'd0, 32'd2, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 32'd0, 3'd0, 1'b0);
    check_eq("shadow_hold", regs_flat[31:0], 0);
    cycle(1'b0, 3'd0, 32'd0, 3'd0, 1'b1);
    check_eq("shadow_sync", regs_flat[31:0], 2);
    cycle(1'b1, 3'd0, 32'd5, 3'd0, 1'b1);
    check_eq("shadow_bypass", regs_flat[31:0], 5);
`endif

    // reset while a pulse is mid-hold and registers are populated
    cycle(1'b1, 3'd0, 32'd5, 3'd0, 1'b1);
    cycle(1'b1, 3'd3, 32'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 32'd0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 32'd0, 3'd0, 1'b0);
    check_eq("pre_rst_trig", sfx_trig, 3'b001);
    check_eq("pre_rst_rd", rd_data, 5);
    do_reset("rst_mid");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic          we, fs;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      if (i == 200) do_reset("rst_rand");
      we = ($urandom_range(0, 9) < 6);
      wa = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && wa > 3'd3) wa = AW'($urandom_range(0, 3));
      wd = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 4)) : DW'($urandom);
      ra = AW'($urandom_range(0, 7));
      fs = ($urandom_range(0, 4) == 0);
      cycle(we, wa, wd, ra, fs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
